// File: rtl/mips_pkg.sv
// Shared execute-stage definitions: ALU control encodings and multiply/divide FSM states.
package mips_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [3:0] ALUCON_MULT = 4'b0110;
  localparam logic [3:0] ALUCON_DIV  = 4'b0101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Operates on magnitudes (one bit per cycle) and applies the sign fix when writing HI/LO.
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUcon,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t    r_state;
  muldiv_state_t    w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_done;

  logic             w_valid_op;
  logic             w_last;
  logic             w_launch;
  logic             w_move;
  logic             w_iter;
  logic             w_finish;

  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_dshift;
  logic               w_dfits;
  logic [WIDTH-1:0]   w_dsub;
  logic [2*WIDTH-1:0] w_div_next;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    if (n) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic n);
    if (n) begin
      return ~v + (2*WIDTH)'(1);
    end else begin
      return v;
    end
  endfunction

  assign w_valid_op = (ALUcon == ALUCON_MULT) || (ALUcon == ALUCON_DIV);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  // Shift-add step: multiplier sits in the low half and is consumed LSB first.
  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};

  // Restoring step: partial remainder in the high half, quotient shifts into the low half.
  assign w_dshift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_dfits    = (w_dshift >= {1'b0, r_opb});
  assign w_dsub     = w_dshift[WIDTH-1:0] - r_opb;
  assign w_div_next = w_dfits ? {w_dsub, r_acc[WIDTH-2:0], 1'b1}
                              : {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next_state = FINISH;
        end else begin
          w_next_state = RUN;
        end
      end
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Per-state control strobes; a launch always takes priority over a move.
  always_comb begin
    w_launch = 1'b0;
    w_move   = 1'b0;
    w_iter   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE: begin
        w_launch = start & w_valid_op;
        w_move   = (mthi | mtlo) & ~(start & w_valid_op);
      end
      RUN:     w_iter   = 1'b1;
      FINISH:  w_finish = 1'b1;
      default: w_launch = 1'b0;
    endcase
  end

  // Operand capture, iteration datapath and HI/LO update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= {CW{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_opb    <= {WIDTH{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_launch) begin
        r_is_div <= (ALUcon == ALUCON_DIV);
        r_neg_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg_r  <= signed_op & a[WIDTH-1];
        r_div0   <= (b == {WIDTH{1'b0}});
        r_cnt    <= {CW{1'b0}};
        if (ALUcon == ALUCON_DIV) begin
          r_opb <= neg_if(b, signed_op & b[WIDTH-1]);
          r_acc <= {{WIDTH{1'b0}}, neg_if(a, signed_op & a[WIDTH-1])};
        end else begin
          r_opb <= neg_if(a, signed_op & a[WIDTH-1]);
          r_acc <= {{WIDTH{1'b0}}, neg_if(b, signed_op & b[WIDTH-1])};
        end
      end else if (w_iter) begin
        r_acc <= r_is_div ? w_div_next : w_mul_next;
        r_cnt <= r_cnt + CW'(1);
      end else if (w_finish) begin
        if (r_is_div) begin
          // Divide by zero leaves |a| as remainder, so the sign fix restores a in HI.
          r_hi <= neg_if(r_acc[2*WIDTH-1:WIDTH], r_neg_r);
          r_lo <= r_div0 ? {WIDTH{1'b1}} : neg_if(r_acc[WIDTH-1:0], r_neg_q);
        end else begin
          {r_hi, r_lo} <= neg_if2(r_acc, r_neg_q);
        end
      end else if (w_move) begin
        if (mthi) begin
          r_hi <= a;
        end
        if (mtlo) begin
          r_lo <= a;
        end
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != IDLE);
  assign done = r_done;

endmodule
